nios_cpu_div_cell: RTL and testbench

//  Iterative radix-2 restoring divider; inverse-operation companion to the CPU multiply cell.

---
 rtl/nios_cpu_div_cell_if.sv | 26 ++
 rtl/nios_cpu_div_cell.sv | 118 +++++++++++
 tb/tb_nios_cpu_div_cell.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios_cpu_div_cell_if.sv
// Pipeline-side bundle for the iterative divider: E-stage request, M-stage result.
// E_start is a request taken only when the divider is idle and M_en=1; M_div_done is a one-cycle result strobe.
interface nios_cpu_div_cell_if #(
  parameter int DATA_W = 32
);
  logic              E_start;
  logic              E_signed;
  logic [DATA_W-1:0] E_src1;
  logic [DATA_W-1:0] E_src2;
  logic              E_kill;
  logic              M_en;
  logic              M_div_busy;
  logic              M_div_done;
  logic [DATA_W-1:0] M_div_quot;
  logic [DATA_W-1:0] M_div_rem;

  modport master (
    output E_start, E_signed, E_src1, E_src2, E_kill, M_en,
    input  M_div_busy, M_div_done, M_div_quot, M_div_rem
  );

  modport slave (
    input  E_start, E_signed, E_src1, E_src2, E_kill, M_en,
    output M_div_busy, M_div_done, M_div_quot, M_div_rem
  );
endinterface

// File: rtl/nios_cpu_div_cell.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per enabled cycle,
// sign fix-up after the loop, registered quotient/remainder with a done pulse.
module nios_cpu_div_cell #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                clk,
   input  logic                reset,
   nios_cpu_div_cell_if.slave  div,
   output logic [2:0]          dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              state, state_nx;
   logic                sgn, q_neg, r_neg;
   logic [DATA_W-1:0]   rem, dvd, dvs;
   logic [DATA_W-1:0]   quot_q, rem_q;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W:0]     shifted, trial;
   logic                adv;

   // Kill overrides everything, including a frozen pipeline.
   assign adv = div.M_en & ~div.E_kill;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (div.E_kill) begin
         state_nx = S_IDLE;
      end else if (div.M_en) begin
         case (state)
            S_IDLE: if (div.E_start) state_nx = S_PREP;
            S_PREP: state_nx = S_ITER;
            S_ITER: if (cnt == CNT_W'(DATA_W-1)) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Trial subtraction; bit DATA_W is the sign of (shifted remainder - divisor).
   always_comb begin
      shifted = {rem, dvd[DATA_W-1]};
      trial   = shifted - {1'b0, dvs};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sgn    <= 1'b0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         rem    <= '0;
         dvd    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         quot_q <= '0;
         rem_q  <= '0;
      end else if (adv) begin
         case (state)
            S_IDLE: begin
               if (div.E_start) begin
                  sgn <= div.E_signed;
                  dvd <= div.E_src1;
                  dvs <= div.E_src2;
               end
            end
            S_PREP: begin
               if (sgn) begin
                  dvd   <= dvd[DATA_W-1] ? -dvd : dvd;
                  dvs   <= dvs[DATA_W-1] ? -dvs : dvs;
                  q_neg <= dvd[DATA_W-1] ^ dvs[DATA_W-1];
                  r_neg <= dvd[DATA_W-1];
               end else begin
                  q_neg <= 1'b0;
                  r_neg <= 1'b0;
               end
               rem <= '0;
               cnt <= '0;
            end
            S_ITER: begin
               // Dividend bits shift out the top while quotient bits fill in at the bottom.
               if (!trial[DATA_W]) begin
                  rem <= trial[DATA_W-1:0];
                  dvd <= {dvd[DATA_W-2:0], 1'b1};
               end else begin
                  rem <= shifted[DATA_W-1:0];
                  dvd <= {dvd[DATA_W-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
            end
            S_FIX: begin
               quot_q <= q_neg ? -dvd : dvd;
               rem_q  <= r_neg ? -rem : rem;
            end
            default: ;
         endcase
      end
   end

   assign div.M_div_busy = (state != S_IDLE);
   assign div.M_div_done = (state == S_DONE);
   assign div.M_div_quot = quot_q;
   assign div.M_div_rem  = rem_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_nios_cpu_div_cell.sv
// Directed and randomized checks of nios_cpu_div_cell against an arithmetic reference.
module tb_nios_cpu_div_cell;

  localparam int DATA_W = 32;
  localparam int LAT    = DATA_W + 2;  // enabled edges from start edge to done visible

  logic clk;
  logic reset;
  logic [2:0] dbg_state;
  int compared;
  int mismatched;
  logic [DATA_W-1:0] last_q, last_r;

  nios_cpu_div_cell_if #(.DATA_W(DATA_W)) div_if ();

  nios_cpu_div_cell #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .div       (div_if),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: plain integer division with the documented corner-case results
  task automatic ref_div(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic s,
                         output logic [DATA_W-1:0] q, output logic [DATA_W-1:0] r);
    longint sa, sb;
    if (!s) begin
      if (b == 0) begin q = '1; r = a; end
      else begin q = a / b; r = a % b; end
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
        q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
        r = a;
      end else begin
        q = DATA_W'(sa / sb);
        r = DATA_W'(sa % sb);
      end
    end
  endtask

  // driver: one operation from start to post-done idle
  task automatic run_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic s,
                        input int stall_pct, input int stall_from, input int stall_len,
                        input bit dup_start, input string tag,
                        output int edges, output int busy_cyc);
    logic [DATA_W-1:0] eq, er;
    int en_edges;
    bit got;
    ref_div(a, b, s, eq, er);
    div_if.E_src1   = a;
    div_if.E_src2   = b;
    div_if.E_signed = s;
    div_if.E_start  = 1'b1;
    div_if.M_en     = 1'b1;
    step();
    div_if.E_start = 1'b0;
    edges = 0; en_edges = 0; busy_cyc = 0; got = 1'b0;
    while (!got && edges < 400) begin
      if (div_if.M_div_busy && !div_if.M_div_done) busy_cyc++;
      if (edges >= stall_from && edges < stall_from + stall_len) div_if.M_en = 1'b0;
      else div_if.M_en = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      if (dup_start && edges == 3) begin
        div_if.E_start = 1'b1;
        div_if.E_src1  = $urandom;
        div_if.E_src2  = $urandom;
        div_if.E_signed = ~s;
      end else begin
        div_if.E_start = 1'b0;
      end
      step();
      edges++;
      if (div_if.M_en) en_edges++;
      got = div_if.M_div_done;
    end
    div_if.E_start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_en_edges"}, en_edges, LAT);
    check({tag, "_quot"}, div_if.M_div_quot, eq);
    check({tag, "_rem"}, div_if.M_div_rem, er);
    last_q = eq;
    last_r = er;
    if (stall_pct > 0 && $urandom_range(3) == 0) begin
      div_if.M_en = 1'b0;
      step();
      check({tag, "_done_hold"}, 32'(div_if.M_div_done), 32'd1);
    end
    // a start presented during the done cycle must be dropped
    div_if.M_en    = 1'b1;
    div_if.E_start = ($urandom_range(1) == 1);
    step();
    div_if.E_start = 1'b0;
    check({tag, "_idle_busy"}, 32'(div_if.M_div_busy), 32'd0);
    check({tag, "_idle_done"}, 32'(div_if.M_div_done), 32'd0);
  endtask

  initial begin
    int edges, busy_cyc;
    compared = 0; mismatched = 0;
    last_q = '0; last_r = '0;
    reset = 1'b1;
    div_if.E_start = 1'b0; div_if.E_signed = 1'b0; div_if.E_kill = 1'b0;
    div_if.E_src1 = '0; div_if.E_src2 = '0; div_if.M_en = 1'b1;
    step(); step();
    check("rst_busy", 32'(div_if.M_div_busy), 32'd0);
    check("rst_done", 32'(div_if.M_div_done), 32'd0);
    check("rst_quot", div_if.M_div_quot, 32'd0);
    check("rst_rem", div_if.M_div_rem, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    step();

    // basic unsigned latency and busy window
    run_op(32'd100, 32'd7, 1'b0, 0, 1000, 0, 1'b0, "u100_7", edges, busy_cyc);
    check("u100_7_edges", edges, 34);
    check("u100_7_busy", busy_cyc, 34);
    check("u100_7_q14", div_if.M_div_quot, 32'd14);

    // signed sign rules
    run_op(-32'sd100, 32'd7, 1'b1, 0, 1000, 0, 1'b0, "s_m100_7", edges, busy_cyc);
    check("s_m100_7_q", div_if.M_div_quot, 32'hFFFF_FFF2);
    check("s_m100_7_r", div_if.M_div_rem, 32'hFFFF_FFFE);
    run_op(32'd100, -32'sd7, 1'b1, 0, 1000, 0, 1'b0, "s_100_m7", edges, busy_cyc);
    check("s_100_m7_r", div_if.M_div_rem, 32'd2);

    // divide by zero and overflow
    run_op(32'd5, 32'd0, 1'b0, 0, 1000, 0, 1'b0, "u5_0", edges, busy_cyc);
    check("u5_0_edges", edges, 34);
    check("u5_0_q", div_if.M_div_quot, 32'hFFFF_FFFF);
    run_op(-32'sd5, 32'd0, 1'b1, 0, 1000, 0, 1'b0, "s_m5_0", edges, busy_cyc);
    check("s_m5_0_q", div_if.M_div_quot, 32'd1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1000, 0, 1'b0, "s_ovf", edges, busy_cyc);
    check("s_ovf_q", div_if.M_div_quot, 32'h8000_0000);
    check("s_ovf_r", div_if.M_div_rem, 32'd0);

    // ten stalled cycles mid-loop
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 10, 10, 1'b0, "u_stall", edges, busy_cyc);
    check("u_stall_edges", edges, 44);

    // kill mid-loop while frozen: no done, results untouched
    div_if.E_src1 = 32'd100; div_if.E_src2 = 32'd7; div_if.E_signed = 1'b0;
    div_if.E_start = 1'b1; div_if.M_en = 1'b1;
    step();
    div_if.E_start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("kill_pre_busy", 32'(div_if.M_div_busy), 32'd1);
    div_if.E_kill = 1'b1; div_if.M_en = 1'b0;
    step();
    div_if.E_kill = 1'b0; div_if.M_en = 1'b1;
    check("kill_busy", 32'(div_if.M_div_busy), 32'd0);
    check("kill_done", 32'(div_if.M_div_done), 32'd0);
    check("kill_quot", div_if.M_div_quot, last_q);
    check("kill_rem", div_if.M_div_rem, last_r);
    step();
    check("kill_after_done", 32'(div_if.M_div_done), 32'd0);

    // start while busy is ignored
    run_op(32'd9, 32'd3, 1'b0, 0, 1000, 0, 1'b1, "u9_3_dup", edges, busy_cyc);
    check("u9_3_dup_q", div_if.M_div_quot, 32'd3);
    check("u9_3_dup_edges", edges, 34);

    // kill beats start in the same cycle
    div_if.E_src1 = 32'd50; div_if.E_src2 = 32'd5;
    div_if.E_start = 1'b1; div_if.E_kill = 1'b1;
    step();
    div_if.E_start = 1'b0; div_if.E_kill = 1'b0;
    check("kill_vs_start_busy", 32'(div_if.M_div_busy), 32'd0);

    // asynchronous reset mid-loop
    div_if.E_src1 = 32'd100; div_if.E_src2 = 32'd7;
    div_if.E_start = 1'b1;
    step();
    div_if.E_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(div_if.M_div_busy), 32'd0);
    check("arst_done", 32'(div_if.M_div_done), 32'd0);
    check("arst_quot", div_if.M_div_quot, 32'd0);
    check("arst_rem", div_if.M_div_rem, 32'd0);
    step();
    reset = 1'b0;
    step();
    run_op(32'd1000, 32'd10, 1'b0, 0, 1000, 0, 1'b0, "u1000_10", edges, busy_cyc);
    check("u1000_10_q", div_if.M_div_quot, 32'd100);

    // randomized operands, modes and stalls
    for (int n = 0; n < 800; n++) begin
      logic [DATA_W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(5))
        0: b = b >> $urandom_range(31);
        1: a = a >> $urandom_range(31);
        2: b = ($urandom_range(3) == 0) ? 32'd0 : 32'hFFFF_FFFF;
        3: a = ($urandom_range(1) == 0) ? 32'h8000_0000 : a;
        default: ;
      endcase
      run_op(a, b, 1'($urandom_range(1)), 15, 1000, 0, 1'b0, "rnd", edges, busy_cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
